accum_wrap_monitor: RTL and testbench
=====================================

// Module: accum_wrap_monitor
// PURPOSE
//  Downstream stage of the 4-bit accumulator. Samples its running sum y every clk, detects modulo wrap-around,
//  and extends the sum to EXT_W bits (wrap count in the upper bits).
//  Raises a valid/ready event each time the extended sum crosses the next multiple of THRESH.
//  Feeds a consumer such as a display or logging stage.
// PARAMETERS
//  IN_W    4      width of accumulator sum input
//  EXT_W   8      width of extended sum; EXT_W-IN_W upper bits hold the wrap count
//  THRESH  40     event step; targets are THRESH, 2*THRESH, ... while target < 2**EXT_W
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        ASYNCHRONOUS, ACTIVE-LOW reset (0 = reset)
//  clear      in   1        sync clear; same effect as reset, applied on the clock edge
//  y_in       in   IN_W     accumulator running sum
//  ext_sum    out  EXT_W    registered extended sum {wrap_cnt, y}
//  sat        out  1        sticky: wrap count saturated
//  out_valid  out  1        threshold event pending
//  out_ready  in   1        consumer accepts the event
//  out_data   out  EXT_W    ext_sum captured at the crossing
//  overrun    out  1        sticky: crossing occurred while an event was pending (tied 0 without macro)
// BEHAVIOUR
//  Reset (reset=0, async) or clear=1 (sync): ext_sum=0, sat=0, out_valid=0, out_data=0, overrun=0,
//    prev=0, target=THRESH, state=IDLE.
//  Wrap rule: upstream adds 0..2**IN_W-1 per cycle, so at most one wrap per cycle. wrap <=> y_in < prev.
//    y_in == prev means no wrap.
//  Latency: ext_sum reflects y_in sampled 1 clk earlier. out_valid rises the same cycle ext_sum first shows
//    a value >= target.
//  Saturation: on a wrap with wrap_cnt all ones: sat=1, ext_sum forced to all ones, then frozen until reset/clear.
//  State IDLE: first sample after reset/clear loads prev=y_in, ext_sum={0,y_in}, then goes to TRACK.
//    No wrap is tested on this sample.
//  State TRACK: update prev and ext_sum every cycle.
//    If next ext_sum >= target: out_data<=next ext_sum, out_valid<=1, go to PEND.
//  State PEND: out_valid and out_data held stable; tracking continues.
//    On out_valid&&out_ready: out_valid<=0; target+=THRESH.
//    If the new target would exceed 2**EXT_W-1, go to DONE; else go to TRACK.
//    If the ext_sum already >= the new target, the next event fires one cycle after the handshake,
//      never in the handshake cycle.
//  State DONE: tracking continues; no further events until reset/clear.
//  Target arithmetic uses EXT_W+1 bits to detect overflow. All compares are unsigned.
//  Reset mid-PEND drops out_valid immediately (async). The pending event is lost, not replayed.
// CONFIGURATION
//  ACCUM_MON_OVERRUN_EN defined: in PEND, if the next ext_sum >= target+THRESH, then overrun<=1 (sticky until reset/clear).
//  ACCUM_MON_OVERRUN_EN undefined: no overrun logic; overrun port driven constant 0; port list unchanged.
// STRUCTURE
//  Package accum_mon_pkg: state typedef enum {IDLE, TRACK, PEND, DONE}.
//    Default width constants IN_W/EXT_W and the WRAP_W=EXT_W-IN_W derivation.
//  Sub-module accum_wrap_detect: prev register plus y_in<prev compare. Outputs wrap (1 bit), cleared by reset/clear.
//  Top: wrap counter with saturation, ext_sum register, target register, FSM, output handshake regs.
// TESTING (IN_W=4, EXT_W=8, THRESH=40)
//  1. Wrap: reset, then y_in 0,5,10,15,3 -> ext_sum 0,5,10,15,0x13 (19). sat=0, out_valid=0.
//  2. No-wrap on equal: y_in 7,7,7 -> ext_sum stays 7, wrap count 0.
//  3. Event: ext_sum 35 then 41, out_ready=0 -> out_valid=1, out_data=41, held 5 cycles.
//     Raise out_ready -> out_valid=0 next cycle; next event at ext_sum >= 80.
//  4. Overrun (macro on): pending event 41, ready low, ext_sum reaches 81 -> overrun=1, out_data stays 41.
//     Macro off -> overrun stays 0.
//  5. Saturation: force 16 wraps -> ext_sum=255, sat=1, later y_in changes leave ext_sum 255. DONE after event 240.
//  6. Async reset in PEND: drop reset between edges -> out_valid, ext_sum, overrun go 0 before the next edge.
//     clear=1 for 1 cycle gives the same values after the edge.

Source files
------------

// File: rtl/accum_mon_pkg.sv
// Shared types and default widths for the accumulator wrap monitor.
package accum_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    PEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IN_W_DEF   = 4;
  localparam int EXT_W_DEF  = 8;
  localparam int WRAP_W_DEF = EXT_W_DEF - IN_W_DEF;
  localparam int THRESH_DEF = 40;

endpackage

// File: rtl/accum_wrap_detect.sv
// Remembers the previous accumulator sample and flags a modulo wrap (current sample below previous).
module accum_wrap_detect
  import accum_mon_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clear,
  input  logic [IN_W-1:0] i_y,
  output logic            o_wrap
);

  logic [IN_W-1:0] r_prev;

  // previous-sample register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_prev <= '0;
    end else if (i_clear) begin
      r_prev <= '0;
    end else begin
      r_prev <= i_y;
    end
  end

  // equal samples are a zero-add, not a full-range wrap
  assign o_wrap = !i_clear && (i_y < r_prev);

endmodule

// File: rtl/accum_wrap_monitor.sv
// Extends an accumulator sum with a saturating wrap count and raises valid/ready threshold events.
// Define ACCUM_MON_OVERRUN_EN to enable the sticky overrun flag; otherwise overrun is tied low.
module accum_wrap_monitor
  import accum_mon_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int EXT_W  = EXT_W_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [IN_W-1:0]  y_in,
  output logic [EXT_W-1:0] ext_sum,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXT_W-1:0] out_data,
  output logic             overrun
);

  localparam int             WRAP_W  = EXT_W - IN_W;
  localparam logic [EXT_W:0] STEP    = (EXT_W+1)'(THRESH);
  localparam logic [EXT_W:0] EXT_MAX = {1'b0, {EXT_W{1'b1}}};

  state_t            r_state, w_state_nxt;
  logic [EXT_W-1:0]  r_ext_sum, w_ext_nxt;
  logic              r_sat, w_sat_nxt;
  logic              r_valid, w_valid_nxt;
  logic [EXT_W-1:0]  r_data, w_data_nxt;
  logic [EXT_W:0]    r_target, w_target_nxt;
  logic [EXT_W:0]    w_target_inc;
  logic [WRAP_W-1:0] w_wrap_cnt, w_cnt_inc;
  logic              w_wrap;
  logic              w_ext_ge_tgt;

  accum_wrap_detect #(.IN_W(IN_W)) u_wrap_detect (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (clear),
    .i_y     (y_in),
    .o_wrap  (w_wrap)
  );

  assign w_wrap_cnt   = r_ext_sum[EXT_W-1:IN_W];
  assign w_cnt_inc    = w_wrap_cnt + WRAP_W'(1);
  assign w_target_inc = r_target + STEP;
  assign w_ext_ge_tgt = ({1'b0, w_ext_nxt} >= r_target);

  // next extended sum: load in IDLE, freeze once saturated
  always_comb begin
    w_ext_nxt = r_ext_sum;
    w_sat_nxt = r_sat;
    if (r_state == IDLE) begin
      w_ext_nxt = {{WRAP_W{1'b0}}, y_in};
    end else if (r_sat) begin
      w_ext_nxt = r_ext_sum;
    end else if (w_wrap) begin
      if (&w_wrap_cnt) begin
        w_sat_nxt = 1'b1;
        w_ext_nxt = {EXT_W{1'b1}};
      end else begin
        w_ext_nxt = {w_cnt_inc, y_in};
      end
    end else begin
      w_ext_nxt = {w_wrap_cnt, y_in};
    end
  end

`ifdef ACCUM_MON_OVERRUN_EN
  logic r_ovr, w_ovr_nxt;
  logic w_ext_ge_inc;
  assign w_ext_ge_inc = ({1'b0, w_ext_nxt} >= w_target_inc);
  assign overrun      = r_ovr;
`else
  assign overrun = 1'b0;
`endif

  // event FSM next-state and handshake outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_data_nxt   = r_data;
    w_target_nxt = r_target;
`ifdef ACCUM_MON_OVERRUN_EN
    w_ovr_nxt    = r_ovr;
`endif
    case (r_state)
      IDLE: w_state_nxt = TRACK;
      TRACK: begin
        if (w_ext_ge_tgt) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_ext_nxt;
          w_state_nxt = PEND;
        end else begin
          w_state_nxt = TRACK;
        end
      end
      PEND: begin
`ifdef ACCUM_MON_OVERRUN_EN
        if (w_ext_ge_inc) begin
          w_ovr_nxt = 1'b1;
        end else begin
          w_ovr_nxt = r_ovr;
        end
`endif
        // the new target is only compared from TRACK, so a re-fire waits one cycle
        if (r_valid && out_ready) begin
          w_valid_nxt  = 1'b0;
          w_target_nxt = w_target_inc;
          w_state_nxt  = (w_target_inc > EXT_MAX) ? DONE : TRACK;
        end else begin
          w_state_nxt = PEND;
        end
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else if (clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ext_sum <= '0;
      r_sat     <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_target  <= STEP;
`ifdef ACCUM_MON_OVERRUN_EN
      r_ovr     <= 1'b0;
`endif
    end else if (clear) begin
      r_ext_sum <= '0;
      r_sat     <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_target  <= STEP;
`ifdef ACCUM_MON_OVERRUN_EN
      r_ovr     <= 1'b0;
`endif
    end else begin
      r_ext_sum <= w_ext_nxt;
      r_sat     <= w_sat_nxt;
      r_valid   <= w_valid_nxt;
      r_data    <= w_data_nxt;
      r_target  <= w_target_nxt;
`ifdef ACCUM_MON_OVERRUN_EN
      r_ovr     <= w_ovr_nxt;
`endif
    end
  end

  assign ext_sum   = r_ext_sum;
  assign sat       = r_sat;
  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: tb/tb_accum_wrap_monitor.sv
// Directed self-checking bench for accum_wrap_monitor (IN_W=4, EXT_W=8, THRESH=40).
module tb_accum_wrap_monitor;

  logic       clk = 1'b0;
  logic       reset, clear, out_ready;
  logic [3:0] y_in;
  logic [7:0] ext_sum, out_data;
  logic       sat, out_valid, overrun;
  logic       exp_ovr;
  int         n_checks = 0;
  int         n_fail   = 0;

  accum_wrap_monitor #(.IN_W(4), .EXT_W(8), .THRESH(40)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .y_in      (y_in),
    .ext_sum   (ext_sum),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // present y at the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic [3:0] y);
    @(negedge clk);
    y_in = y;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ext"},   ext_sum,   32'd0);
    check_eq({tag, "_sat"},   sat,       32'd0);
    check_eq({tag, "_valid"}, out_valid, 32'd0);
    check_eq({tag, "_data"},  out_data,  32'd0);
    check_eq({tag, "_ovr"},   overrun,   32'd0);
  endtask

  initial begin
`ifdef ACCUM_MON_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    reset = 1'b0; clear = 1'b0; out_ready = 1'b0; y_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // 1: wrap detection
    step(4'd0);  check_eq("t1_ext0", ext_sum, 32'd0);
    step(4'd5);  check_eq("t1_ext5", ext_sum, 32'd5);
    step(4'd10); check_eq("t1_ext10", ext_sum, 32'd10);
    step(4'd15); check_eq("t1_ext15", ext_sum, 32'd15);
    step(4'd3);  check_eq("t1_wrap", ext_sum, 32'd19);
    check_eq("t1_sat", sat, 32'd0);
    check_eq("t1_valid", out_valid, 32'd0);

    // 2: equal samples are not wraps
    clear = 1'b1; step(4'd9); clear = 1'b0;
    check_zero("clear");
    for (int i = 0; i < 3; i++) begin
      step(4'd7);
      check_eq("t2_eq", ext_sum, 32'd7);
    end

    // 3: event at 41, held, handshake, next event at 80
    step(4'd2); check_eq("t3_ext18", ext_sum, 32'd18);
    step(4'd3); check_eq("t3_ext19", ext_sum, 32'd19);
    step(4'd1); check_eq("t3_ext33", ext_sum, 32'd33);
    step(4'd3); check_eq("t3_ext35", ext_sum, 32'd35);
    check_eq("t3_novalid35", out_valid, 32'd0);
    step(4'd9); check_eq("t3_ext41", ext_sum, 32'd41);
    check_eq("t3_valid41", out_valid, 32'd1);
    check_eq("t3_data41", out_data, 32'd41);
    for (int i = 0; i < 5; i++) begin
      step(4'd9);
      check_eq("t3_hold_valid", out_valid, 32'd1);
      check_eq("t3_hold_data", out_data, 32'd41);
    end
    out_ready = 1'b1;
    step(4'd9); check_eq("t3_hs_valid", out_valid, 32'd0);
    out_ready = 1'b0;
    step(4'd0);  check_eq("t3_ext48", ext_sum, 32'd48);
    step(4'd15); step(4'd0); step(4'd15);
    check_eq("t3_ext79", ext_sum, 32'd79);
    check_eq("t3_novalid79", out_valid, 32'd0);
    step(4'd0);
    check_eq("t3_valid80", out_valid, 32'd1);
    check_eq("t3_data80", out_data, 32'd80);

    // 4: overrun while event 41 is pending
    clear = 1'b1; step(4'd4); clear = 1'b0;
    check_zero("clear_pend");
    step(4'd0); step(4'd15); step(4'd0); step(4'd15); step(4'd9);
    check_eq("t4_valid41", out_valid, 32'd1);
    check_eq("t4_data41", out_data, 32'd41);
    step(4'd0); step(4'd15); step(4'd0); step(4'd15);
    check_eq("t4_ovr79", overrun, 32'd0);
    step(4'd1);
    check_eq("t4_ext81", ext_sum, 32'd81);
    check_eq("t4_ovr81", overrun, {31'd0, exp_ovr});
    check_eq("t4_data_kept", out_data, 32'd41);
    check_eq("t4_valid_kept", out_valid, 32'd1);

    // 6: async reset between edges while pending
    #2 reset = 1'b0;
    #1;
    check_zero("t6_async");
    @(negedge clk);
    reset = 1'b1;
    step(4'd15); step(4'd0); step(4'd15); step(4'd9);
    check_eq("t6_refire", out_valid, 32'd1);
    clear = 1'b1; step(4'd2); clear = 1'b0;
    check_zero("t6_clear");

    // 5: saturation with ready held high; last event at 240 then DONE
    out_ready = 1'b1;
    step(4'd0);
    for (int i = 0; i < 15; i++) begin
      step(4'd15);
      step(4'd0);
    end
    check_eq("t5_ext240", ext_sum, 32'd240);
    check_eq("t5_valid240", out_valid, 32'd1);
    check_eq("t5_data240", out_data, 32'd240);
    step(4'd15);
    check_eq("t5_ext255", ext_sum, 32'd255);
    check_eq("t5_sat_pre", sat, 32'd0);
    check_eq("t5_hs240", out_valid, 32'd0);
    step(4'd0);
    check_eq("t5_sat", sat, 32'd1);
    check_eq("t5_ext_sat", ext_sum, 32'd255);
    step(4'd3); step(4'd9); step(4'd1);
    check_eq("t5_frozen", ext_sum, 32'd255);
    check_eq("t5_sat_sticky", sat, 32'd1);
    check_eq("t5_done_novalid", out_valid, 32'd0);
    check_eq("t5_done_data", out_data, 32'd240);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
